// File: rtl/elevator_pkg.sv
// Shared constants for the elevator scheduler: state codes, default sizing, direction.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elevator_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_MOVE_UP   = 4'd1;
  localparam logic [3:0] ST_MOVE_DOWN = 4'd2;
  localparam logic [3:0] ST_DOOR      = 4'd7;

  localparam int DEFAULT_FLOORS  = 8;
  localparam int DEFAULT_FLOOR_W = 3;

  localparam logic DIR_UP = 1'b1;

  // Status code for travelling in the given sweep direction.
  function automatic logic [3:0] move_code(input logic dir_up);
    return (dir_up == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
  endfunction

endpackage

// File: rtl/elevator_scheduler_if.sv
// Bundle between the call-latching input stage (master) and the scheduler (slave).
// Latency: n/a (wires only).
// Backpressure: none; clear strobes are fire-and-forget, the input stage must act next cycle.
interface elevator_scheduler_if
  import elevator_pkg::*;
#(
  parameter int FLOORS  = DEFAULT_FLOORS,
  parameter int FLOOR_W = DEFAULT_FLOOR_W
);
  logic [FLOORS-1:0]  up;
  logic [FLOORS-1:0]  down;
  logic [FLOORS-1:0]  elevator_btn;
  logic [FLOOR_W-1:0] floor;
  logic [3:0]         status;
  logic               dir_up;
  logic               nextup;
  logic               nextdown;

  modport master (
    output up, down, elevator_btn,
    input  floor, status, dir_up, nextup, nextdown
  );

  modport slave (
    input  up, down, elevator_btn,
    output floor, status, dir_up, nextup, nextdown
  );
endinterface

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by travel and door timing; zero flag when the count is 0.
// Latency: load takes effect on the next edge; zero is a combinational view of the count.
// Backpressure: none; holds at zero until reloaded.
module elevator_timer
  import elevator_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] count_q;

  // Load wins over counting; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/elevator_scheduler.sv
// SCAN car controller: sweeps in one direction serving calls, reverses at the last request.
// Latency: 1 cycle from a sampled request to a state change; MOVE_CYCLES per floor.
// Backpressure: none; clear strobes last one cycle and the same floor is not re-strobed on the next.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS      = DEFAULT_FLOORS,
  parameter int FLOOR_W     = DEFAULT_FLOOR_W,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  elevator_scheduler_if.slave  bus
);
  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);

  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [3:0]         status_q, status_d;
  logic               dir_q, dir_d;
  logic               nextup_q, nextup_d;
  logic               nextdown_q, nextdown_d;
  logic               arrived_q, arrived_d;

  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_zero;

  logic [FLOORS-1:0]  up_m, down_m, req;
  logic               above, below, ahead, behind;
  logic               here, up_here, down_here, btn_here, same_here, opp_here;
  logic               strobed;

  elevator_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .zero  (tmr_zero)
  );

  // No up call exists at the top floor and no down call at the bottom floor.
  always_comb begin
    up_m             = bus.up;
    up_m[FLOORS-1]   = 1'b0;
    down_m           = bus.down;
    down_m[0]        = 1'b0;
  end

  assign req = up_m | down_m | bus.elevator_btn;

  // Split pending requests into strictly above / strictly below the car.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(floor_q)) above = above | req[i];
      if (i < int'(floor_q)) below = below | req[i];
    end
  end

  assign ahead     = dir_q ? above : below;
  assign behind    = dir_q ? below : above;
  assign here      = req[floor_q];
  assign up_here   = up_m[floor_q];
  assign down_here = down_m[floor_q];
  assign btn_here  = bus.elevator_btn[floor_q];
  assign same_here = dir_q ? up_here : down_here;
  assign opp_here  = dir_q ? down_here : up_here;
  // The input stage still shows the served bits during the strobe cycle.
  assign strobed   = nextup_q | nextdown_q;

  // Next-state decision for the car.
  always_comb begin
    floor_d    = floor_q;
    status_d   = status_q;
    dir_d      = dir_q;
    nextup_d   = 1'b0;
    nextdown_d = 1'b0;
    arrived_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = MOVE_LOAD;
    case (status_q)
      ST_IDLE: begin
        if (here) begin
          status_d = ST_DOOR;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
          if (up_here || btn_here) begin
            dir_d    = DIR_UP;
            nextup_d = 1'b1;
          end else begin
            dir_d      = ~DIR_UP;
            nextdown_d = 1'b1;
          end
        end else if (ahead) begin
          status_d = move_code(dir_q);
          tmr_load = 1'b1;
        end else if (behind) begin
          dir_d    = ~dir_q;
          status_d = move_code(~dir_q);
          tmr_load = 1'b1;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (arrived_q && (btn_here || same_here || (!ahead && opp_here))) begin
          status_d = ST_DOOR;
          tmr_load = 1'b1;
          tmr_val  = DOOR_LOAD;
          // Reverse here only when this floor ends the sweep and the opposite call is waiting.
          if (same_here || ahead || !opp_here) begin
            nextup_d   = dir_q;
            nextdown_d = ~dir_q;
          end else begin
            dir_d      = ~dir_q;
            nextup_d   = ~dir_q;
            nextdown_d = dir_q;
          end
        end else if (arrived_q && !ahead) begin
          // Nothing further this way (including all calls withdrawn): let idle pick again.
          status_d = ST_IDLE;
        end else if (tmr_zero) begin
          floor_d   = (status_q == ST_MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          tmr_load  = 1'b1;
          arrived_d = 1'b1;
        end
      end
      ST_DOOR: begin
        if (!strobed && (same_here || btn_here)) begin
          tmr_load   = 1'b1;
          tmr_val    = DOOR_LOAD;
          nextup_d   = dir_q;
          nextdown_d = ~dir_q;
        end else if (tmr_zero) begin
          if (ahead) begin
            status_d = move_code(dir_q);
            tmr_load = 1'b1;
          end else if (behind) begin
            dir_d    = ~dir_q;
            status_d = move_code(~dir_q);
            tmr_load = 1'b1;
          end else begin
            status_d = ST_IDLE;
          end
        end
      end
      default: status_d = ST_IDLE;
    endcase
  end

  // Car state registers; reset snaps the car back to floor 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      floor_q    <= '0;
      status_q   <= ST_IDLE;
      dir_q      <= DIR_UP;
      nextup_q   <= 1'b0;
      nextdown_q <= 1'b0;
      arrived_q  <= 1'b0;
    end else begin
      floor_q    <= floor_d;
      status_q   <= status_d;
      dir_q      <= dir_d;
      nextup_q   <= nextup_d;
      nextdown_q <= nextdown_d;
      arrived_q  <= arrived_d;
    end
  end

  assign bus.floor    = floor_q;
  assign bus.status   = status_q;
  assign bus.dir_up   = dir_q;
  assign bus.nextup   = nextup_q;
  assign bus.nextdown = nextdown_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with MOVE_CYCLES=2, DOOR_CYCLES=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_elevator_scheduler;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   both_cnt = 0;

  elevator_scheduler_if #(.FLOORS(8), .FLOOR_W(3)) bus();

  elevator_scheduler #(
    .FLOORS(8), .FLOOR_W(3), .MOVE_CYCLES(2), .DOOR_CYCLES(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Both clear strobes high in one cycle is never legal.
  always @(negedge clk) begin
    if (bus.nextup && bus.nextdown) both_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] set_up;
    logic [7:0] set_down;
    logic [7:0] set_btn;
    int         ticks;
    logic [2:0] floor;
    logic [3:0] status;
    logic       dir;
    logic       nu;
    logic       nd;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [7:0] u, input logic [7:0] d, input logic [7:0] b,
                     input int n, input logic [2:0] f, input logic [3:0] s,
                     input logic dr, input logic nu, input logic nd);
    vec_t v;
    v.set_up = u; v.set_down = d; v.set_btn = b; v.ticks = n;
    v.floor = f; v.status = s; v.dir = dr; v.nu = nu; v.nd = nd;
    vt.push_back(v);
  endtask

  // One clock of the input stage: drop the bits addressed by a strobe seen in the previous cycle.
  task automatic tick();
    logic       su, sd;
    logic [2:0] f;
    su = bus.nextup;
    sd = bus.nextdown;
    f  = bus.floor;
    @(posedge clk);
    #1;
    if (su) begin
      bus.up[f]           = 1'b0;
      bus.elevator_btn[f] = 1'b0;
    end
    if (sd) begin
      bus.down[f]         = 1'b0;
      bus.elevator_btn[f] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [2:0] f, input logic [3:0] s,
                       input logic dr, input logic nu, input logic nd);
    tests++;
    if ({bus.floor, bus.status, bus.dir_up, bus.nextup, bus.nextdown} !== {f, s, dr, nu, nd}) begin
      fails++;
      $display("FAIL %s: got floor=%0d status=%0d dir_up=%0b nextup=%0b nextdown=%0b, want floor=%0d status=%0d dir_up=%0b nextup=%0b nextdown=%0b",
               name, bus.floor, bus.status, bus.dir_up, bus.nextup, bus.nextdown, f, s, dr, nu, nd);
    end
  endtask

  initial begin
    bool_init();
  end

  task automatic bool_init();
    bit found;
    // Serve a call at the resting floor; the stale bit during the strobe cycle must not re-strobe.
    add(8'h01, 8'h00, 8'h00, 1, 3'd0, ST_DOOR,      1, 1, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd0, ST_DOOR,      1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd0, ST_DOOR,      1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd0, ST_IDLE,      1, 0, 0);
    // Car button 4: one floor every two cycles, stop with nextup.
    add(8'h00, 8'h00, 8'h10, 1, 3'd0, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 2, 3'd1, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 2, 3'd2, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 2, 3'd3, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 2, 3'd4, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd4, ST_DOOR,      1, 1, 0);
    // down[6] and up[2]: reverse at 6, sweep down, reverse again at 2.
    add(8'h04, 8'h40, 8'h00, 2, 3'd4, ST_DOOR,      1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd4, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 2, 3'd5, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 2, 3'd6, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd6, ST_DOOR,      0, 0, 1);
    add(8'h00, 8'h00, 8'h00, 3, 3'd6, ST_MOVE_DOWN, 0, 0, 0);
    add(8'h00, 8'h00, 8'h00, 2, 3'd5, ST_MOVE_DOWN, 0, 0, 0);
    add(8'h00, 8'h00, 8'h00, 6, 3'd2, ST_MOVE_DOWN, 0, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd2, ST_DOOR,      1, 1, 0);
    add(8'h00, 8'h00, 8'h00, 3, 3'd2, ST_IDLE,      1, 0, 0);
    // down[3] skipped on the way up to button 7, served on the way down.
    add(8'h00, 8'h08, 8'h80, 1, 3'd2, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 2, 3'd3, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 8, 3'd7, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd7, ST_DOOR,      1, 1, 0);
    add(8'h00, 8'h00, 8'h00, 3, 3'd7, ST_MOVE_DOWN, 0, 0, 0);
    add(8'h00, 8'h00, 8'h00, 8, 3'd3, ST_MOVE_DOWN, 0, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd3, ST_DOOR,      0, 0, 1);
    add(8'h00, 8'h00, 8'h00, 3, 3'd3, ST_IDLE,      0, 0, 0);
    // Idle facing down with only a request above: flip and go up.
    add(8'h00, 8'h00, 8'h10, 1, 3'd3, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 3, 3'd4, ST_DOOR,      1, 1, 0);
    add(8'h00, 8'h00, 8'h00, 3, 3'd4, ST_IDLE,      1, 0, 0);
    // Requests both sides with dir_up=1: up first, then down to 1.
    add(8'h40, 8'h02, 8'h00, 1, 3'd4, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 4, 3'd6, ST_MOVE_UP,   1, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd6, ST_DOOR,      1, 1, 0);
    add(8'h00, 8'h00, 8'h00, 3, 3'd6, ST_MOVE_DOWN, 0, 0, 0);
    add(8'h00, 8'h00, 8'h00, 10, 3'd1, ST_MOVE_DOWN, 0, 0, 0);
    add(8'h00, 8'h00, 8'h00, 1, 3'd1, ST_DOOR,      0, 0, 1);
    add(8'h00, 8'h00, 8'h00, 3, 3'd1, ST_IDLE,      0, 0, 0);
    // up[7] and down[0] do not exist and must not move the car.
    add(8'h80, 8'h01, 8'h00, 2, 3'd1, ST_IDLE,      0, 0, 0);

    rst = 1'b1;
    bus.up = '0;
    bus.down = '0;
    bus.elevator_btn = '0;
    tick();
    tick();
    check("reset", 3'd0, ST_IDLE, 1, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      bus.up           = bus.up | vt[i].set_up;
      bus.down         = bus.down | vt[i].set_down;
      bus.elevator_btn = bus.elevator_btn | vt[i].set_btn;
      for (int k = 0; k < vt[i].ticks; k++) tick();
      check($sformatf("vec%0d", i), vt[i].floor, vt[i].status, vt[i].dir, vt[i].nu, vt[i].nd);
    end

    // Reset while travelling up at floor 5.
    bus.up = '0;
    bus.down = '0;
    bus.elevator_btn = 8'h80;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.floor == 3'd5 && bus.status == ST_MOVE_UP) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reach_floor5: got floor=%0d status=%0d, want floor=5 status=%0d within 100 cycles",
               bus.floor, bus.status, ST_MOVE_UP);
    end
    rst = 1'b1;
    tick();
    check("reset_mid_move", 3'd0, ST_IDLE, 1, 0, 0);
    rst = 1'b0;
    bus.elevator_btn = '0;
    tick();
    check("after_reset_idle", 3'd0, ST_IDLE, 1, 0, 0);

    // Car button reappears while the door is open: re-strobe and hold the door longer.
    bus.elevator_btn = 8'h01;
    tick();
    check("door_open", 3'd0, ST_DOOR, 1, 1, 0);
    tick();
    bus.elevator_btn = 8'h01;
    tick();
    check("restrobe", 3'd0, ST_DOOR, 1, 1, 0);
    tick();
    tick();
    check("door_held", 3'd0, ST_DOOR, 1, 0, 0);
    tick();
    check("door_close", 3'd0, ST_IDLE, 1, 0, 0);

    tests++;
    if (both_cnt != 0) begin
      fails++;
      $display("FAIL strobe_exclusive: got %0d cycles with both strobes, want 0", both_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask
endmodule
